pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

- Generates a programmable burst of active-low pulses on a single line `signal_out`.
- Pulse count, low width and high width are loaded with a one-cycle `start`.
- Acts as the transmit end of the falling-edge pulse-counting link: each pulse produces exactly one falling edge for the counting side to register.
- All outputs are registered, so the line is glitch-free for a multi-flop synchronizer at the far end.

## Interface
- `CNT_W`, default 8: width of pulse count and `pulses_sent`.
- `WID_W`, default 8: width of the low/high phase-length fields.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `start`  in  1  load-and-go strobe; sampled only in IDLE.
- `count`  in  `CNT_W`  number of pulses to emit; latched on an accepted `start`.
- `low_cycles`  in  `WID_W`  low-phase length in clocks; 0 is treated as 1; latched on an accepted `start`.
- `high_cycles`  in  `WID_W`  high-phase length after each low phase; 0 is treated as 1; latched on an accepted `start`.
- `abort`  in  1  terminates a burst; the line returns high.
- `signal_out`  out  1  pulse line; idle level high.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle strobe when a burst completes normally.
- `pulses_sent`  out  `CNT_W`  falling edges emitted in the current or last burst.

## Operation
- Reset values:
  - `signal_out`=1, `busy`=0, `done`=0, `pulses_sent`=0.
  - FSM in IDLE; internal registers cleared.
- FSM states: IDLE, LOW, HIGH, FIN.
- IDLE:
  - `start`=1, `abort`=0, `count`≠0: latch `count`, `max(low_cycles,1)` and `max(high_cycles,1)`; clear `pulses_sent`; go to LOW.
  - `start`=1, `count`=0: clear `pulses_sent`; go to FIN; no pulse is emitted.
- LOW:
  - `signal_out`=0 for exactly L clocks.
  - `pulses_sent` increments by 1 on entry, i.e. in the same cycle the line falls.
  - Then go to HIGH.
- HIGH:
  - `signal_out`=1 for exactly H clocks.
  - If remaining pulses > 0, go to LOW; otherwise go to FIN.
  - The final pulse is always followed by a full H-clock high phase, so the receiver sees a settled high before `done`.
- FIN: `done`=1 and `busy`=0 for one cycle; go to IDLE.
- `busy`=1 exactly in LOW and HIGH.
- `start` while `busy`: ignored; latched parameters do not change.
- `abort` in LOW or HIGH:
  - Next cycle: IDLE, `signal_out`=1, `busy`=0, no `done`.
  - `pulses_sent` holds the edges already emitted.
- `abort` together with `start` in IDLE: `abort` wins and nothing starts.
- `reset` mid-burst: all outputs return to reset values on the next edge; no `done`.
- Phase counters are `WID_W`-bit down-counters and never wrap.
- `pulses_sent` never exceeds the latched count; maximum is 2^CNT_W−1.

## Timing
- `start` sampled at edge k: `signal_out` falls and `busy` rises in the cycle after edge k.
- Burst length: `busy` is high for N·(L+H) cycles.
- `done` asserts in the cycle immediately after `busy` falls.
- Back-to-back bursts: a `start` sampled in the `done` cycle is ignored (FSM in FIN). The earliest accepted restart is the cycle after `done`.
- `count`=0: `done` pulses one cycle after `start`; `busy` never rises.
- `abort` sampled at edge m: `signal_out`=1 and `busy`=0 from edge m+1.

## Test plan
- Reset check: assert `reset` for 2 clocks mid-burst -> `signal_out`=1, `busy`=0, `done`=0, `pulses_sent`=0 on the first edge; no further edges.
- Nominal burst: `count`=3, L=2, H=3 -> `signal_out` pattern 0,0,1,1,1 repeated 3 times, starting one cycle after `start`. `busy` high for 15 cycles; `done` in the cycle after; `pulses_sent`=3.
- Degenerate settings, part 1: `count`=0 -> no line activity; `done` one cycle after `start`; `pulses_sent`=0.
- Degenerate settings, part 2: `count`=4, L=0, H=0 -> line alternates 0,1 for 8 cycles; `pulses_sent`=4.
- Busy protection: `start` with `count`=9 issued while a `count`=2 burst is running -> exactly 2 pulses and one `done`; a second `start` one cycle after `done` launches 9 pulses.
- Abort: `count`=10, L=H=4, `abort` during the third low phase -> line high on the next cycle; `busy`=0; no `done`; `pulses_sent`=3. A simultaneous `start`+`abort` in IDLE -> nothing starts.
- Full scale: `count`=255, L=H=1 -> exactly 255 falling edges over 510 busy cycles; `pulses_sent`=255; one `done`.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a programmable burst of active-low pulses.
// Each pulse is L clocks low and then H clocks high. The final high phase
// completes before done, so the far end sees a settled high line.
// Every output is a flop, so the line never glitches.
//
// Handshake: start is a single-cycle strobe that is accepted only in IDLE
// (the FSM is the implicit ready). A start seen in any other state is dropped.
// abort beats start in IDLE. In LOW or HIGH, abort ends the burst without done.
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int WID_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [WID_W-1:0] low_cycles,
   input  logic [WID_W-1:0] high_cycles,
   input  logic             abort,
   output logic             signal_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pulses_sent,
   output logic [1:0]       state_dbg
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt_q;
   logic [WID_W-1:0] low_q;
   logic [WID_W-1:0] high_q;
   logic [WID_W-1:0] phase_q;
   logic [WID_W-1:0] low_eff;
   logic [WID_W-1:0] high_eff;

   // A phase length of zero is promoted to one clock.
   always_comb begin
      low_eff  = (low_cycles  == '0) ? WID_W'(1) : low_cycles;
      high_eff = (high_cycles == '0) ? WID_W'(1) : high_cycles;
   end

   assign state_dbg = state;

   // Burst FSM: phase down-counter, pulse tally, and the registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt_q       <= '0;
         low_q       <= WID_W'(1);
         high_q      <= WID_W'(1);
         phase_q     <= '0;
         signal_out  <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         pulses_sent <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  if (count != '0) begin
                     // The first falling edge is counted in the cycle the line drops.
                     cnt_q       <= count;
                     low_q       <= low_eff;
                     high_q      <= high_eff;
                     phase_q     <= low_eff - WID_W'(1);
                     pulses_sent <= CNT_W'(1);
                     signal_out  <= 1'b0;
                     busy        <= 1'b1;
                     state       <= S_LOW;
                  end else begin
                     pulses_sent <= '0;
                     done        <= 1'b1;
                     state       <= S_FIN;
                  end
               end
            end
            S_LOW: begin
               if (abort) begin
                  signal_out <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end else if (phase_q == '0) begin
                  signal_out <= 1'b1;
                  phase_q    <= high_q - WID_W'(1);
                  state      <= S_HIGH;
               end else begin
                  phase_q <= phase_q - WID_W'(1);
               end
            end
            S_HIGH: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (phase_q == '0) begin
                  if (pulses_sent != cnt_q) begin
                     pulses_sent <= pulses_sent + CNT_W'(1);
                     signal_out  <= 1'b0;
                     phase_q     <= low_q - WID_W'(1);
                     state       <= S_LOW;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end else begin
                  phase_q <= phase_q - WID_W'(1);
               end
            end
            default: begin
               // FIN: done is high for this one cycle, then the FSM idles.
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed tests for pulse_train_gen with a cycle-level expected model.
module tb_pulse_train_gen;

   localparam int CNT_W = 8;
   localparam int WID_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] count;
   logic [WID_W-1:0] low_cycles;
   logic [WID_W-1:0] high_cycles;
   logic             abort;
   logic             signal_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulses_sent;
   logic [1:0]       state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   pulse_train_gen #(.CNT_W(CNT_W), .WID_W(WID_W)) dut (
      .clk(clk), .reset(reset), .start(start), .count(count),
      .low_cycles(low_cycles), .high_cycles(high_cycles), .abort(abort),
      .signal_out(signal_out), .busy(busy), .done(done),
      .pulses_sent(pulses_sent), .state_dbg(state_dbg)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag, input int exp_sent);
      check_eq({tag, ".sig"},  32'(signal_out), 32'd1);
      check_eq({tag, ".busy"}, 32'(busy), 32'd0);
      check_eq({tag, ".done"}, 32'(done), 32'd0);
      check_eq({tag, ".sent"}, 32'(pulses_sent), 32'(exp_sent));
   endtask

   // Starts a burst from a negedge in IDLE and checks every cycle up to one
   // cycle after done. inject_at is the burst cycle at which to raise a stray start.
   // A negative value means no stray start. With start_in_done set, start is
   // raised during the done cycle, where it must be ignored.
   task automatic burst(input string tag, input int n, input int l, input int h,
                        input int inject_at, input bit start_in_done);
      int le, he, idx, falls;
      logic prev;
      le = (l == 0) ? 1 : l;
      he = (h == 0) ? 1 : h;
      idx = 0;
      falls = 0;
      prev = signal_out;
      start = 1'b1;
      count = CNT_W'(n);
      low_cycles = WID_W'(l);
      high_cycles = WID_W'(h);
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < n; p++) begin
         for (int c = 0; c < le + he; c++) begin
            if (prev && !signal_out) falls++;
            prev = signal_out;
            check_eq({tag, ".sig"},  32'(signal_out), (c < le) ? 32'd0 : 32'd1);
            check_eq({tag, ".busy"}, 32'(busy), 32'd1);
            check_eq({tag, ".done"}, 32'(done), 32'd0);
            check_eq({tag, ".sent"}, 32'(pulses_sent), 32'(p + 1));
            if (idx == inject_at) begin
               start = 1'b1;
               count = 8'd9;
               low_cycles = 8'd5;
               high_cycles = 8'd6;
            end
            idx++;
            @(negedge clk);
            start = 1'b0;
         end
      end
      // Done cycle.
      check_eq({tag, ".fin_done"}, 32'(done), 32'd1);
      check_eq({tag, ".fin_busy"}, 32'(busy), 32'd0);
      check_eq({tag, ".fin_sig"},  32'(signal_out), 32'd1);
      check_eq({tag, ".fin_sent"}, 32'(pulses_sent), 32'(n));
      check_eq({tag, ".falls"},    32'(falls), 32'(n));
      if (start_in_done) begin
         start = 1'b1;
         count = 8'd5;
      end
      @(negedge clk);
      start = 1'b0;
      check_idle({tag, ".after"}, n);
      check_eq({tag, ".state"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      count = '0;
      low_cycles = '0;
      high_cycles = '0;
      repeat (3) @(negedge clk);
      check_idle("reset", 0);
      check_eq("reset.state", 32'(state_dbg), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Nominal burst: 3 pulses of 2 clocks low and 3 clocks high.
      burst("nominal", 3, 2, 3, -1, 1'b0);

      // A count of zero produces done only.
      burst("zero", 0, 5, 5, -1, 1'b0);

      // Zero-length phases are promoted to one clock.
      burst("min_w", 4, 0, 0, -1, 1'b0);

      // A stray start during the burst and a start in the done cycle are both ignored.
      burst("prot", 2, 1, 1, 1, 1'b1);
      burst("restart", 9, 1, 1, -1, 1'b0);

      // Abort during the third low phase. Each pulse is 8 cycles, so the third low starts at index 16.
      start = 1'b1;
      count = 8'd10;
      low_cycles = 8'd4;
      high_cycles = 8'd4;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 18; i++) begin
         check_eq("abort.sig", 32'(signal_out), ((i % 8) < 4) ? 32'd0 : 32'd1);
         check_eq("abort.sent", 32'(pulses_sent), 32'(i / 8 + 1));
         if (i == 17) abort = 1'b1;
         @(negedge clk);
      end
      abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_idle("abort.post", 3);
         @(negedge clk);
      end

      // start and abort together in IDLE: nothing starts.
      start = 1'b1;
      abort = 1'b1;
      count = 8'd5;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle("start_abort", 3);
         check_eq("start_abort.state", 32'(state_dbg), 32'd0);
         @(negedge clk);
      end

      // Reset in the middle of a burst.
      start = 1'b1;
      count = 8'd5;
      low_cycles = 8'd2;
      high_cycles = 8'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("pre_reset.busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_idle("mid_reset", 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_idle("post_reset", 0);
      end

      // Full scale: 255 pulses of 1 clock low and 1 clock high.
      burst("full", 255, 1, 1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
